serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Serial frame transmitter. Accepts a parallel word on a valid/ready handshake and shifts it out
//   on a single line, one bit per bit-period: start(0), data LSB-first, [parity], stop(1).
//   It is the driving end of the serial bit stream that the capture flops and receiver sample.
// PARAMETERS
//   WIDTH         8  data bits per frame (>=1)
//   CLKS_PER_BIT  4  clk cycles each bit is held on tx_out (>=1)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      reset, asynchronous, active-low (0 = reset)
//   tx_data   in   WIDTH  word to send; sampled only on handshake
//   tx_valid  in   1      source has a word
//   tx_ready  out  1      block can accept a word (high only in IDLE)
//   tx_out    out  1      serial line; idles high
//   tx_busy   out  1      frame in progress (START..STOP)
//   tx_done   out  1      one-cycle pulse: frame completed
// BEHAVIOUR
//   - All outputs registered. Reset (rst=0, any time incl. mid-frame) forces immediately: state=IDLE,
//     tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, shift reg=0, counters=0. Partial frame is discarded.
//   - Handshake: transfer on rising edge with tx_valid&tx_ready. tx_data captured into shift reg;
//     next cycle tx_ready=0, tx_busy=1, tx_out=0 (start bit). tx_valid/tx_data ignored while busy.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     Each of START, every DATA bit, PARITY, STOP lasts exactly CLKS_PER_BIT cycles (baud counter
//     0..CLKS_PER_BIT-1; phase advances when counter == CLKS_PER_BIT-1, counter wraps to 0).
//     DATA: bit index 0..WIDTH-1, tx_out = captured bit[index]; leave DATA after index WIDTH-1.
//   - Frame length N = (WIDTH+2[+1 parity])*CLKS_PER_BIT cycles of tx_busy=1.
//   - Last STOP cycle: next edge -> IDLE, tx_busy=0, tx_ready=1, tx_done=1 for that one cycle only.
//   - Back-to-back: a word presented with tx_valid held high is accepted in the first IDLE cycle
//     (same cycle tx_done=1); next start bit follows one cycle later. Min gap = 1 idle cycle (line high).
//   - CLKS_PER_BIT=1: one cycle per bit, no special casing. Counter widths via $clog2, min 1 bit.
// CONFIGURATION
//   SERIAL_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, tx_out = even parity
//     (XOR of the WIDTH captured bits), held CLKS_PER_BIT cycles. Not defined: DATA goes directly to STOP,
//     no parity logic present.
// STRUCTURE
//   Package serial_tx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), line level constants
//     LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
//   Sub-module tx_baud_counter: CLKS_PER_BIT counter with clear input, emits bit_tick on terminal
//     count; top holds FSM, shift register and bit index.
// TESTING (CLKS_PER_BIT=4, WIDTH=8 unless stated)
//   1 Hold rst=0 with toggling inputs -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
//   2 Send 8'hA5 -> tx_out 0 x4, then 1,0,1,0,0,1,0,1 x4 each, then 1 x4; tx_busy=1 for 40 cycles;
//     tx_done one pulse; tx_ready low whole frame.
//   3 tx_valid held high with 8'h01 then 8'hFF -> two frames, exactly one idle-high cycle between,
//     tx_done pulses twice; tx_data changes mid-frame do not alter the serial bits.
//   4 Pull rst low at cycle 15 of a frame -> tx_out=1, tx_busy=0 same time; after release, a new
//     8'h3C frame is clean and complete.
//   5 SERIAL_TX_PARITY_EN, send 8'h07 -> parity bit 1 after data; 8'h03 -> 0; frame = 44 cycles.
//   6 CLKS_PER_BIT=1, send 8'h80 -> 0,0,0,0,0,0,0,0,1,1 one cycle each; tx_done after 10 cycles.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and line-level constants for the serial frame transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module tx_baud_counter
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_comb begin
    bit_tick = 1'b0;
    if (!clear && (cnt == LAST)) bit_tick = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, data LSB-first, optional even parity, stop.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int unsigned IW = cnt_width(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_e        state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    next_idx;
  logic             bit_tick;
  logic             baud_clear;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_bit;
`endif

  always_comb begin
    baud_clear = 1'b0;
    next_idx   = bit_idx + IW'(1);
    if (state == IDLE) baud_clear = 1'b1;
  end

  tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  // tx_out is loaded with the level of the phase being entered, so it stays registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      tx_out   <= LINE_IDLE;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= ^tx_data;
`endif
            state    <= START;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            tx_out   <= START_BIT;
          end
        end
        START: begin
          if (bit_tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx_out  <= shreg[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= parity_bit;
`else
              state  <= STOP;
              tx_out <= STOP_BIT;
`endif
            end else begin
              bit_idx <= next_idx;
              tx_out  <= shreg[next_idx];
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state  <= STOP;
            tx_out <= STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            state    <= IDLE;
            tx_busy  <= 1'b0;
            tx_ready <= 1'b1;
            tx_done  <= 1'b1;
            tx_out   <= LINE_IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          tx_busy  <= 1'b0;
          tx_ready <= 1'b1;
          tx_out   <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (CLKS_PER_BIT=4 and CLKS_PER_BIT=1 instances).
// Honours SERIAL_TX_PARITY_EN for the expected frame layout.
module tb_serial_frame_tx;

  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_out, tx_busy, tx_done;
  logic [7:0] tx_data1;
  logic       tx_valid1;
  logic       tx_ready1, tx_out1, tx_busy1, tx_done1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data1),
    .tx_valid(tx_valid1),
    .tx_ready(tx_ready1),
    .tx_out  (tx_out1),
    .tx_busy (tx_busy1),
    .tx_done (tx_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bits, index 0 = start bit; parity digit is entered by hand per call.
  function automatic logic [11:0] fr(input logic [7:0] d, input logic p);
`ifdef SERIAL_TX_PARITY_EN
    return {1'b0, 1'b1, p, d, 1'b0};
`else
    return {2'b00, 1'b1, d ^ {8{p & 1'b0}}, 1'b0};
`endif
  endfunction

  // Called with the word already presented; returns on the tx_done sample.
  task automatic watch_frame(input string tag, input logic [11:0] bits,
                             input logic nv, input logic [7:0] nd);
    int  busy_n = 0;
    int  done_n = 0;
    int  ready_bad = 0;
    int  k;
    bit  fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check({tag, "_first_busy"}, 32'(tx_busy), 32'(1));
        tx_valid = nv;
        tx_data  = nd;
      end
      if (tx_busy) begin
        k = busy_n / CPB;
        if (k < NB) check({tag, "_bit"}, 32'(tx_out), 32'(bits[k]));
        if (tx_ready) ready_bad++;
        busy_n++;
      end
      if (tx_done) begin
        done_n++;
        check({tag, "_done_line"}, 32'({tx_out, tx_ready, tx_busy}), 32'(3'b110));
        fin = 1;
      end
    end
    check({tag, "_done_seen"}, 32'(done_n), 32'(1));
    check({tag, "_busy_len"}, 32'(busy_n), 32'(NB * CPB));
    check({tag, "_ready_low"}, 32'(ready_bad), 32'(0));
  endtask

  initial begin
    logic [11:0] got;
    int          n1;
    int          done_at;

    rst = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_valid1 = 1'b0; tx_data1 = '0;

    // 1: reset held with toggling inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_dut", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));
      check("rst_dut1", 32'({tx_out1, tx_ready1, tx_busy1, tx_done1}), 32'(4'b1100));
      tx_valid = ~tx_valid; tx_data = 8'(i * 37 + 5);
      tx_valid1 = ~tx_valid1; tx_data1 = 8'(i * 11 + 3);
    end
    tx_valid = 1'b0; tx_valid1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));

    // 2: single 8'hA5 frame (even parity 0)
    tx_valid = 1'b1; tx_data = 8'hA5;
    watch_frame("a5", fr(8'hA5, 1'b0), 1'b0, 8'h5A);
    @(negedge clk);
    check("a5_done_pulse", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));

    // 3: back-to-back with tx_valid held, data changed mid-frame
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h01;
    watch_frame("b2b_01", fr(8'h01, 1'b1), 1'b1, 8'hFF);
    watch_frame("b2b_ff", fr(8'hFF, 1'b0), 1'b0, 8'h00);
    @(negedge clk);
    check("b2b_idle", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));

    // 4: reset at cycle 15 of a frame, then clean 8'h3C frame
    tx_valid = 1'b1; tx_data = 8'hF0;
    @(negedge clk);
    tx_valid = 1'b0;
    check("mid_busy", 32'(tx_busy), 32'(1));
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_now", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_hold", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", 32'({tx_out, tx_ready, tx_busy, tx_done}), 32'(4'b1100));
    tx_valid = 1'b1; tx_data = 8'h3C;
    watch_frame("after_rst_3c", fr(8'h3C, 1'b0), 1'b0, 8'h00);

    // 5: parity-sensitive words (07 -> parity 1, 03 -> parity 0)
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h07;
    watch_frame("w07", fr(8'h07, 1'b1), 1'b0, 8'h00);
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h03;
    watch_frame("w03", fr(8'h03, 1'b0), 1'b0, 8'h00);

    // 6: CLKS_PER_BIT=1 instance sends 8'h80 (parity 1)
    @(negedge clk);
    tx_valid1 = 1'b1; tx_data1 = 8'h80;
    got = '0; n1 = 0; done_at = -1;
    for (int c = 0; c < 50 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 0) tx_valid1 = 1'b0;
      if (tx_busy1) begin
        if (n1 < 12) got[n1] = tx_out1;
        n1++;
      end
      if (tx_done1) done_at = c;
    end
    check("cpb1_bits", 32'(got), 32'(fr(8'h80, 1'b1)));
    check("cpb1_len", 32'(n1), 32'(NB));
    check("cpb1_done_at", 32'(done_at), 32'(NB));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
